chorus_mod_delay: RTL

- Modulated fractional delay line; generates the wet path of the chorus effect.
- Consumes the chorus wet input stream and writes every sample into a circular buffer.
- Reads the buffer back at a delay swept by a triangle LFO, with linear interpolation between adjacent taps.
- Output feeds the chorus wet/dry mix.

---
 rtl/chorus_mod_delay.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/chorus_mod_delay.sv
// Modulated fractional delay line for the chorus wet path: a circular sample buffer
// read back at a triangle-LFO-swept delay with linear interpolation between two taps.
module chorus_mod_delay #(
  parameter int width_p      = 24,
  parameter int depth_p      = 1024,
  parameter int base_delay_p = 480,
  parameter int mod_depth_p  = 96,
  parameter int frac_bits_p  = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic signed [width_p-1:0] data_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [15:0]               rate_i,
  output logic signed [width_p-1:0] data_o,
  output logic                      valid_o,
  input  logic                      ready_i
);

  localparam int AW   = $clog2(depth_p);
  localparam int F    = frac_bits_p;
  localparam int LIM  = (2 * mod_depth_p) << F;
  localparam int MID  = mod_depth_p << F;
  localparam int TW   = $clog2(LIM + 1);
  localparam int LW   = TW + 18;
  localparam int KMIN = base_delay_p - mod_depth_p;
  localparam int PW   = width_p + 1 + F;

  localparam logic signed [LW-1:0] LIM_S  = LW'(LIM);
  localparam logic signed [LW-1:0] ZERO_S = '0;

  typedef enum logic [2:0] {S_IDLE, S_RD0, S_RD1, S_CALC, S_OUT} state_t;

  state_t r_state;
  state_t w_state_next;

  logic signed [width_p-1:0] r_mem [depth_p];
  logic signed [width_p-1:0] r_rd_data;

  logic [AW-1:0]             r_wptr;
  logic [AW:0]               r_cnt;
  logic [TW-1:0]             r_tri;
  logic                      r_dir_down;
  logic [AW-1:0]             r_addr_a;
  logic [AW-1:0]             r_addr_b;
  logic                      r_a_ok;
  logic                      r_b_ok;
  logic [F-1:0]              r_frac;
  logic signed [width_p-1:0] r_a;
  logic signed [width_p-1:0] r_data_o;

  logic                      w_accept;
  logic [AW:0]               w_cnt_next;
  logic [AW:0]               w_k;
  logic [AW-1:0]             w_addr_a;
  logic [AW-1:0]             w_rd_addr;
  logic signed [LW-1:0]      w_tri_ext;
  logic signed [LW-1:0]      w_rate_ext;
  logic signed [LW-1:0]      w_tri_step;
  logic [TW-1:0]             w_tri_new;
  logic                      w_dir_new;
  logic signed [width_p-1:0] w_b;
  logic signed [width_p:0]   w_diff;
  logic signed [PW-1:0]      w_prod;
  logic signed [PW-1:0]      w_shift;
  logic signed [PW-1:0]      w_y_full;

  assign w_accept   = valid_i & ready_o & ~reset_i;
  assign w_cnt_next = (r_cnt == (AW+1)'(depth_p)) ? r_cnt : r_cnt + 1'b1;

  // The LFO value at accept is this sample's delay: integer part selects taps, low bits weight them.
  assign w_k      = (AW+1)'(KMIN) + (AW+1)'(r_tri >> F);
  assign w_addr_a = r_wptr - w_k[AW-1:0];

  assign w_tri_ext  = LW'(r_tri);
  assign w_rate_ext = LW'(rate_i);
  assign w_tri_step = r_dir_down ? (w_tri_ext - w_rate_ext) : (w_tri_ext + w_rate_ext);

  always_comb begin
    w_tri_new = r_tri;
    w_dir_new = r_dir_down;
    if (w_tri_step >= LIM_S) begin
      w_tri_new = TW'(LIM);
      w_dir_new = 1'b1;
    end else if (w_tri_step <= ZERO_S) begin
      w_tri_new = '0;
      w_dir_new = 1'b0;
    end else begin
      w_tri_new = w_tri_step[TW-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (valid_i) w_state_next = S_RD0;
      S_RD0:   w_state_next = S_RD1;
      S_RD1:   w_state_next = S_CALC;
      S_CALC:  w_state_next = S_OUT;
      S_OUT:   if (ready_i) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o = 1'b0;
    valid_o = 1'b0;
    ready_o = (r_state == S_IDLE);
    valid_o = (r_state == S_OUT);
  end

  // Buffer RAM: not reset, so history beyond the fill count is masked instead.
  assign w_rd_addr = (r_state == S_RD1) ? r_addr_b : r_addr_a;

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_mem[r_wptr] <= data_i;
    end
    r_rd_data <= r_mem[w_rd_addr];
  end

  assign w_b      = r_b_ok ? r_rd_data : '0;
  assign w_diff   = $signed({w_b[width_p-1], w_b}) - $signed({r_a[width_p-1], r_a});
  assign w_prod   = PW'(w_diff) * PW'($signed({1'b0, r_frac}));
  assign w_shift  = w_prod >>> F;
  assign w_y_full = PW'(r_a) + w_shift;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wptr     <= '0;
      r_cnt      <= '0;
      r_tri      <= TW'(MID);
      r_dir_down <= 1'b0;
      r_addr_a   <= '0;
      r_addr_b   <= '0;
      r_a_ok     <= 1'b0;
      r_b_ok     <= 1'b0;
      r_frac     <= '0;
      r_a        <= '0;
      r_data_o   <= '0;
    end else begin
      if (w_accept) begin
        r_wptr     <= r_wptr + 1'b1;
        r_cnt      <= w_cnt_next;
        r_tri      <= w_tri_new;
        r_dir_down <= w_dir_new;
        r_addr_a   <= w_addr_a;
        r_addr_b   <= w_addr_a - 1'b1;
        r_a_ok     <= (w_k < w_cnt_next);
        r_b_ok     <= ((w_k + 1'b1) < w_cnt_next);
        r_frac     <= r_tri[F-1:0];
      end
      if (r_state == S_RD1) begin
        r_a <= r_a_ok ? r_rd_data : '0;
      end
      if (r_state == S_CALC) begin
        r_data_o <= w_y_full[width_p-1:0];
      end
    end
  end

  assign data_o = r_data_o;

endmodule
